// File: rtl/fetch_unit_if.sv
// fetch_unit_if: PC mux, instruction memory and decode handshake signals of the fetch stage.
// Squash_Count is present only when FETCH_SQUASH_CNT_EN is defined.
interface fetch_unit_if;
  localparam int unsigned AW = 16;

  logic [AW-1:0] Next_PC;
  logic          Branch_Taken;
  logic          Stall;
  logic [AW-1:0] PC;
  logic [AW-1:0] PC_Plus1;
  logic [AW-1:0] Mem_Addr;
  logic          Mem_Req;
  logic          Mem_Ack;
  logic [AW-1:0] Mem_Data;
  logic [AW-1:0] Instr;
  logic [AW-1:0] Instr_PC;
  logic          Instr_Valid;
`ifdef FETCH_SQUASH_CNT_EN
  logic [AW-1:0] Squash_Count;
`endif

  // Fetch stage side
  modport master (
`ifdef FETCH_SQUASH_CNT_EN
    output Squash_Count,
`endif
    input  Next_PC, Branch_Taken, Stall, Mem_Ack, Mem_Data,
    output PC, PC_Plus1, Mem_Addr, Mem_Req, Instr, Instr_PC, Instr_Valid
  );

  // Environment side: PC mux, memory and decode
  modport slave (
`ifdef FETCH_SQUASH_CNT_EN
    input  Squash_Count,
`endif
    output Next_PC, Branch_Taken, Stall, Mem_Ack, Mem_Data,
    input  PC, PC_Plus1, Mem_Addr, Mem_Req, Instr, Instr_PC, Instr_Valid
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues word reads over req/ack,
// presents the fetched word to decode over valid/stall, and handles branch redirects.
// Optional feature: define FETCH_SQUASH_CNT_EN to add the saturating Squash_Count output.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  localparam int unsigned AW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SQUASH = 2'd2,
    ST_VALID  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] instr_q;
  logic [AW-1:0] instr_pc_q;
  logic          req_q;
  logic          valid_q;
  logic [AW-1:0] squash_tgt_c;

  assign bus.PC          = pc_q;
  assign bus.PC_Plus1    = pc_q + AW'(1);
  assign bus.Mem_Addr    = addr_q;
  assign bus.Mem_Req     = req_q;
  assign bus.Instr       = instr_q;
  assign bus.Instr_PC    = instr_pc_q;
  assign bus.Instr_Valid = valid_q;

  // After a squashed request returns, refetch from the newest redirect target
  assign squash_tgt_c = bus.Branch_Taken ? bus.Next_PC : pc_q;

  // Fetch FSM with registered request/valid outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
          if (bus.Branch_Taken) begin
            pc_q   <= bus.Next_PC;
            addr_q <= bus.Next_PC;
          end else begin
            addr_q <= pc_q;
          end
        end
        ST_REQ: begin
          if (bus.Mem_Ack) begin
            if (bus.Branch_Taken) begin
              // Wrong-path data: drop it and reissue at the target
              pc_q   <= bus.Next_PC;
              addr_q <= bus.Next_PC;
            end else begin
              instr_q    <= bus.Mem_Data;
              instr_pc_q <= addr_q;
              req_q      <= 1'b0;
              valid_q    <= 1'b1;
              state_q    <= ST_VALID;
            end
          end else if (bus.Branch_Taken) begin
            // Request cannot be retracted; keep Mem_Addr until it completes
            pc_q    <= bus.Next_PC;
            state_q <= ST_SQUASH;
          end
        end
        ST_SQUASH: begin
          if (bus.Mem_Ack) begin
            pc_q    <= squash_tgt_c;
            addr_q  <= squash_tgt_c;
            state_q <= ST_REQ;
          end else if (bus.Branch_Taken) begin
            pc_q <= bus.Next_PC;
          end
        end
        ST_VALID: begin
          if (bus.Branch_Taken || !bus.Stall) begin
            pc_q    <= bus.Next_PC;
            addr_q  <= bus.Next_PC;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_SQUASH_CNT_EN
  logic [AW-1:0] squash_cnt_q;
  logic          drop_c;

  assign bus.Squash_Count = squash_cnt_q;

  // One dropped fetch per discarded memory response or discarded held instruction
  always_comb begin
    drop_c = 1'b0;
    case (state_q)
      ST_REQ:    drop_c = bus.Mem_Ack && bus.Branch_Taken;
      ST_SQUASH: drop_c = bus.Mem_Ack;
      ST_VALID:  drop_c = bus.Branch_Taken;
      default:   drop_c = 1'b0;
    endcase
  end

  // Saturating dropped-fetch counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      squash_cnt_q <= '0;
    end else if (drop_c && (squash_cnt_q != {AW{1'b1}})) begin
      squash_cnt_q <= squash_cnt_q + AW'(1);
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit processor. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched instruction to decode with a valid/stall handshake. Sits directly downstream of the next-PC 2:1 mux: it drives the mux's sequential input with `PC_Plus1` and loads the mux output `Next_PC` on every PC update. `Branch_Taken` redirects fetch and squashes wrong-path work.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Next_PC  input  16  next-PC mux output; loaded into PC on consume or redirect.
- Branch_Taken  input  1  redirect request; Next_PC is the target this cycle.
- Stall  input  1  decode not ready; held instruction is not consumed.
- PC  output  16  current fetch PC (register).
- PC_Plus1  output  16  PC + 1 mod 2^16, combinational; feeds mux input A.
- Mem_Addr  output  16  memory read address (register).
- Mem_Req  output  1  read request, high in states REQ and SQUASH.
- Mem_Ack  input  1  memory returns data this cycle; sampled only while Mem_Req=1.
- Mem_Data  input  16  read data, valid when Mem_Ack=1.
- Instr  output  16  fetched instruction (register).
- Instr_PC  output  16  address of Instr (register).
- Instr_Valid  output  1  Instr is valid; high exactly in state VALID.

## Operation
- States: IDLE, REQ, SQUASH, VALID (2-bit encoding). Reset: state=IDLE, PC=Mem_Addr=RESET_PC, Instr=Instr_PC=0, Mem_Req=0, Instr_Valid=0.
- "Load(X)" means PC<=X and Mem_Addr<=X.
- IDLE: always -> REQ. If Branch_Taken=1, Load(Next_PC); otherwise Mem_Addr<=PC.
- REQ, Mem_Ack=1, Branch_Taken=0: Instr<=Mem_Data, Instr_PC<=Mem_Addr, -> VALID.
- REQ, Mem_Ack=1, Branch_Taken=1: data dropped, Load(Next_PC), stay in REQ. This issues a new request.
- REQ, Mem_Ack=0, Branch_Taken=1: PC<=Next_PC, Mem_Addr unchanged, -> SQUASH.
- REQ, Mem_Ack=0, Branch_Taken=0: hold everything.
- SQUASH: the outstanding request completes but its data is discarded.
  - Mem_Ack=1: Mem_Addr<=(Branch_Taken ? Next_PC : PC), with PC updated likewise, -> REQ.
  - Mem_Ack=0, Branch_Taken=1: PC<=Next_PC, stay.
- VALID, Branch_Taken=1: held instruction dropped regardless of Stall, Load(Next_PC), -> REQ.
- VALID, Branch_Taken=0, Stall=0: instruction consumed, Load(Next_PC), -> REQ.
- VALID, Branch_Taken=0, Stall=1: hold Instr, Instr_PC and PC.
- All PC arithmetic is unsigned 16-bit and wraps: PC=16'hFFFF gives PC_Plus1=16'h0000.

## Timing
- Mem_Addr and Mem_Req stay stable from the request cycle until the Mem_Ack edge. A request is never retracted.
- Zero-wait memory (Mem_Ack high in the first REQ cycle):
  - reset release -> IDLE (cycle 0) -> REQ (cycle 1) -> Instr_Valid=1 in cycle 2.
  - steady-state throughput is one instruction per 2 cycles.
- N wait cycles add N cycles of latency.
- Consume and redirect take effect at the same edge. The next cycle shows Instr_Valid=0 and Mem_Req=1 with the new Mem_Addr.
- Reset asserted mid-request or mid-hold forces the reset values immediately (asynchronous). Any in-flight memory data is ignored.

## Configuration
- FETCH_SQUASH_CNT_EN defined: adds output Squash_Count (16 bits).
  - Resets to 0.
  - Increments by 1 on every dropped fetch: REQ/ack/redirect, SQUASH/ack, or VALID/redirect.
  - Saturates at 16'hFFFF.
- FETCH_SQUASH_CNT_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset with RESET_PC=16'h0010, memory always acking with data = addr^16'hA5A5, Next_PC=PC_Plus1, Stall=0 -> Instr sequence 16'hA5B5, 16'hA5B4, ... with Instr_PC 0x0010, 0x0011, ..., Instr_Valid toggling every cycle.
- Stall=1 for 3 cycles while VALID -> Instr, Instr_PC and PC held. Mem_Req=0 throughout. Consume resumes on the first Stall=0 edge.
- Memory acks 3 cycles late with Branch_Taken pulse at cycle 1 of the wait (Next_PC=16'h0040) -> SQUASH, old data discarded, next Mem_Addr=0x0040, Instr_PC=0x0040 delivered. Squash_Count=1 when enabled.
- Branch_Taken with Stall=1 in VALID (Next_PC=16'h0100) -> instruction dropped, Instr_Valid=0 next cycle, Mem_Addr=0x0100.
- PC=16'hFFFF -> PC_Plus1=0x0000. After consume, PC=0x0000.
- Assert Reset while in SQUASH -> next observation shows IDLE values, PC=RESET_PC, Mem_Req=0, Instr_Valid=0. The late Mem_Ack is ignored.
